// File: rtl/apu_serial_mixer.sv
// Time-multiplexed audio mixer: one channel multiply-accumulate per cycle,
// saturated output with a result strobe and per-channel frame-event flags.
`timescale 1ns/1ps
module apu_serial_mixer #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 9,
    parameter int VOLUME_WIDTH = 4,
    parameter int OUT_WIDTH    = 11
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_sample_stb,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_channels,
    input  logic [NUM_CHANNELS*VOLUME_WIDTH-1:0] i_volume,
    input  logic [NUM_CHANNELS-1:0]              i_mixer,
    input  logic [NUM_CHANNELS-1:0]              i_frame_pulse,
    output logic [OUT_WIDTH-1:0]                 o_sample,
    output logic                                 o_sample_stb,
    output logic                                 o_clip,
    output logic                                 o_busy,
    output logic                                 o_overrun,
    output logic [NUM_CHANNELS-1:0]              o_frame_flags
);
    localparam int ACC_W = SAMPLE_WIDTH + VOLUME_WIDTH + $clog2(NUM_CHANNELS) + 1;
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int MIX_W = ACC_W - VOLUME_WIDTH;
    localparam int CMP_W = ((MIX_W > OUT_WIDTH) ? MIX_W : OUT_WIDTH) + 1;
    localparam logic [CMP_W-1:0] MAX_EXT = CMP_W'({OUT_WIDTH{1'b1}});
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    logic [1:0]                          state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [ACC_W-1:0]                    acc_q, acc_d;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] chan_snap_q, chan_snap_d;
    logic [NUM_CHANNELS*VOLUME_WIDTH-1:0] vol_snap_q, vol_snap_d;
    logic [NUM_CHANNELS-1:0]             en_snap_q, en_snap_d;
    logic [NUM_CHANNELS-1:0]             pending_q, pending_d;
    logic [NUM_CHANNELS-1:0]             flags_q, flags_d;
    logic [OUT_WIDTH-1:0]                sample_q, sample_d;
    logic                                clip_q, clip_d;
    logic                                sample_stb_q, sample_stb_d;
    logic                                overrun_q, overrun_d;

    logic [SAMPLE_WIDTH-1:0] chan_arr [NUM_CHANNELS];
    logic [VOLUME_WIDTH-1:0] vol_arr  [NUM_CHANNELS];
    logic [VOLUME_WIDTH:0]   vol_p1;
    logic [ACC_W-1:0]        term;
    logic [CMP_W-1:0]        mix_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
            assign chan_arr[gi] = chan_snap_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            assign vol_arr[gi]  = vol_snap_q[gi*VOLUME_WIDTH +: VOLUME_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        chan_snap_d  = chan_snap_q;
        vol_snap_d   = vol_snap_q;
        en_snap_d    = en_snap_q;
        flags_d      = flags_q;
        sample_d     = sample_q;
        clip_d       = clip_q;
        sample_stb_d = 1'b0;
        overrun_d    = 1'b0;
        pending_d    = pending_q | i_frame_pulse;

        // Volume v scales by (v+1)/2^VOLUME_WIDTH; the divide happens once, after summing.
        vol_p1  = {1'b0, vol_arr[idx_q]} + (VOLUME_WIDTH+1)'(1);
        term    = en_snap_q[idx_q] ? ACC_W'(chan_arr[idx_q]) * ACC_W'(vol_p1) : '0;
        mix_ext = CMP_W'(acc_q[ACC_W-1:VOLUME_WIDTH]);

        case (state_q)
            ST_IDLE: begin
                if (i_sample_stb) begin
                    chan_snap_d = i_channels;
                    vol_snap_d  = i_volume;
                    en_snap_d   = i_mixer;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                overrun_d = i_sample_stb;
                acc_d     = acc_q + term;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                overrun_d = i_sample_stb;
                if (mix_ext > MAX_EXT) begin
                    sample_d = '1;
                    clip_d   = 1'b1;
                end else begin
                    sample_d = mix_ext[OUT_WIDTH-1:0];
                    clip_d   = 1'b0;
                end
                // This cycle's pulses are reported now rather than carried over.
                flags_d      = pending_q | i_frame_pulse;
                pending_d    = '0;
                sample_stb_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            chan_snap_q  <= '0;
            vol_snap_q   <= '0;
            en_snap_q    <= '0;
            pending_q    <= '0;
            flags_q      <= '0;
            sample_q     <= '0;
            clip_q       <= 1'b0;
            sample_stb_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            chan_snap_q  <= chan_snap_d;
            vol_snap_q   <= vol_snap_d;
            en_snap_q    <= en_snap_d;
            pending_q    <= pending_d;
            flags_q      <= flags_d;
            sample_q     <= sample_d;
            clip_q       <= clip_d;
            sample_stb_q <= sample_stb_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_sample      = sample_q;
    assign o_sample_stb  = sample_stb_q;
    assign o_clip        = clip_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_overrun     = overrun_q;
    assign o_frame_flags = flags_q;

endmodule

// File: tb/tb_apu_serial_mixer.sv
// Bench for apu_serial_mixer: default instance plus a narrow-output instance for saturation.
`timescale 1ns/1ps
module tb_apu_serial_mixer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [35:0] ch;
    logic [15:0] vol;
    logic [3:0]  en;
    logic [3:0]  fp;

    logic [10:0] sample_a;
    logic        stb_a, clip_a, busy_a, ovr_a;
    logic [3:0]  flags_a;
    logic [8:0]  sample_b;
    logic        stb_b, clip_b, busy_b, ovr_b;
    logic [3:0]  flags_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apu_serial_mixer dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_channels(ch),
        .i_volume(vol), .i_mixer(en), .i_frame_pulse(fp),
        .o_sample(sample_a), .o_sample_stb(stb_a), .o_clip(clip_a),
        .o_busy(busy_a), .o_overrun(ovr_a), .o_frame_flags(flags_a)
    );

    apu_serial_mixer #(.OUT_WIDTH(9)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_channels(ch),
        .i_volume(vol), .i_mixer(en), .i_frame_pulse(fp),
        .o_sample(sample_b), .o_sample_stb(stb_b), .o_clip(clip_b),
        .o_busy(busy_b), .o_overrun(ovr_b), .o_frame_flags(flags_b)
    );

    // Reference: sum of enabled sample*(volume+1), divided by 16 once at the end.
    function automatic int model_mix(input logic [35:0] c, input logic [15:0] v, input logic [3:0] e);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++)
            if (e[k]) acc += int'(c[k*9 +: 9]) * (int'(v[k*4 +: 4]) + 1);
        return acc / 16;
    endfunction

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Issue one strobe and wait (bounded) for the result; inputs are scrambled after the snapshot.
    task automatic do_mix(input logic [35:0] c, input logic [15:0] v, input logic [3:0] e,
                          output int lat, output logic [19:0] busy_trace);
        ch = c; vol = v; en = e; stb = 1'b1;
        lat = -1;
        busy_trace = '0;
        busy_trace[0] = busy_a;
        for (int k = 1; k < 20; k++) begin
            step();
            stb = 1'b0;
            if (k == 1) begin
                ch  = 36'({$urandom(), $urandom()});
                vol = 16'($urandom());
                en  = 4'($urandom());
            end
            busy_trace[k] = busy_a;
            if (stb_a) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stb = 1'b1; ch = '1; vol = '1; en = '1; fp = '1;
        step(); step();
        checks++; if ({sample_a, stb_a, clip_a, busy_a, ovr_a, flags_a} !== 19'd0) begin
            failures++; $display("FAIL reset_outputs_a got=%h exp=0", {sample_a, stb_a, clip_a, busy_a, ovr_a, flags_a}); end
        checks++; if ({sample_b, stb_b, clip_b, busy_b, ovr_b, flags_b} !== 17'd0) begin
            failures++; $display("FAIL reset_outputs_b got=%h exp=0", {sample_b, stb_b, clip_b, busy_b, ovr_b, flags_b}); end
        stb = 1'b0; fp = '0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (busy_a !== 1'b0) begin
            failures++; $display("FAIL reset_idle got=%b exp=0", busy_a); end
        $display("test_reset done");
    endtask

    task automatic test_unity;
        int lat; logic [19:0] bt;
        do_mix({9'd0, 9'd50, 9'd200, 9'd100}, 16'hFFFF, 4'b1111, lat, bt);
        checks++; if (lat !== 6) begin failures++; $display("FAIL unity_latency got=%0d exp=6", lat); end
        checks++; if (sample_a !== 11'd350) begin failures++; $display("FAIL unity_sample got=%0d exp=350", sample_a); end
        checks++; if (clip_a !== 1'b0) begin failures++; $display("FAIL unity_clip got=%b exp=0", clip_a); end
        checks++; if (bt[6:0] !== 7'b0111110) begin failures++; $display("FAIL unity_busy got=%b exp=0111110", bt[6:0]); end
        step();
        checks++; if (stb_a !== 1'b0 || sample_a !== 11'd350) begin
            failures++; $display("FAIL unity_hold got stb=%b sample=%0d exp stb=0 sample=350", stb_a, sample_a); end
        $display("test_unity lat=%0d sample=%0d", lat, sample_a);
    endtask

    task automatic test_mute_volume;
        int lat; logic [19:0] bt;
        do_mix({4{9'd256}}, {4'd15, 4'd3, 4'd15, 4'd7}, 4'b0101, lat, bt);
        checks++; if (lat !== 6) begin failures++; $display("FAIL mute_latency got=%0d exp=6", lat); end
        checks++; if (sample_a !== 11'd192) begin failures++; $display("FAIL mute_sample got=%0d exp=192", sample_a); end
        $display("test_mute_volume sample=%0d", sample_a);
    endtask

    task automatic test_saturation;
        int lat; logic [19:0] bt;
        do_mix({4{9'd511}}, 16'hFFFF, 4'b1111, lat, bt);
        checks++; if (sample_b !== 9'd511 || clip_b !== 1'b1) begin
            failures++; $display("FAIL sat_narrow got=%0d/%b exp=511/1", sample_b, clip_b); end
        checks++; if (sample_a !== 11'd2044 || clip_a !== 1'b0) begin
            failures++; $display("FAIL sat_wide got=%0d/%b exp=2044/0", sample_a, clip_a); end
        do_mix(36'd0, 16'd0, 4'b1111, lat, bt);
        checks++; if (sample_b !== 9'd0 || clip_b !== 1'b0) begin
            failures++; $display("FAIL sat_quiet got=%0d/%b exp=0/0", sample_b, clip_b); end
        $display("test_saturation done lat=%0d", lat);
    endtask

    task automatic test_frame_flags;
        int lat; logic [19:0] bt;
        ch = {4{9'd10}}; vol = 16'd0; en = 4'b1111; stb = 1'b1; fp = '0;
        lat = -1;
        for (int k = 1; k < 20; k++) begin
            step();
            stb = 1'b0;
            fp = (k == 2) ? 4'b0010 : (k == 5) ? 4'b0100 : 4'b0000;
            if (stb_a) begin lat = k; break; end
        end
        fp = '0;
        checks++; if (lat !== 6) begin failures++; $display("FAIL flags_latency got=%0d exp=6", lat); end
        checks++; if (flags_a !== 4'b0110) begin failures++; $display("FAIL flags_first got=%b exp=0110", flags_a); end
        do_mix(36'd0, 16'd0, 4'd0, lat, bt);
        checks++; if (flags_a !== 4'b0000) begin failures++; $display("FAIL flags_second got=%b exp=0000", flags_a); end
        $display("test_frame_flags done");
    endtask

    task automatic test_overrun;
        logic [13:0] ovr_tr, stb_tr;
        logic [10:0] s6, s12;
        ovr_tr = '0; stb_tr = '0; s6 = '0; s12 = '0;
        ch = {9'd0, 9'd50, 9'd200, 9'd100}; vol = 16'hFFFF; en = 4'b1111; stb = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            ovr_tr[k] = ovr_a; stb_tr[k] = stb_a;
            if (k == 6) s6 = sample_a;
            if (k == 12) s12 = sample_a;
            stb = (k == 3) || (k == 6);
            if (k == 6) begin ch = {4{9'd256}}; vol = {4'd15, 4'd3, 4'd15, 4'd7}; en = 4'b0101; end
        end
        stb = 1'b0;
        checks++; if (ovr_tr !== 14'b00000000010000) begin failures++; $display("FAIL overrun_pulse got=%b exp=%b", ovr_tr, 14'b00000000010000); end
        checks++; if (stb_tr !== 14'b01000001000000) begin failures++; $display("FAIL overrun_stb got=%b exp=%b", stb_tr, 14'b01000001000000); end
        checks++; if (s6 !== 11'd350) begin failures++; $display("FAIL overrun_first got=%0d exp=350", s6); end
        checks++; if (s12 !== 11'd192) begin failures++; $display("FAIL overrun_second got=%0d exp=192", s12); end
        $display("test_overrun ovr=%b stb=%b", ovr_tr, stb_tr);
    endtask

    task automatic test_back_to_back;
        int last_acc, exp_stb_at, m, ea, eb;
        bit next_ovr, stb_now, eca, ecb, exp_busy;
        logic [3:0] pend_m;
        last_acc = -100; exp_stb_at = -1; pend_m = '0;
        ea = 0; eb = 0; eca = 0; ecb = 0;
        for (int c = 0; c < 300; c++) begin
            stb_now = (c < 290) && ($urandom_range(0, 2) == 0);
            ch  = 36'({$urandom(), $urandom()});
            vol = 16'($urandom());
            en  = 4'($urandom());
            fp  = (c < 290 && $urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'd0;
            next_ovr = 1'b0;
            if (stb_now) begin
                if (c >= last_acc + N + 2) begin
                    last_acc = c;
                    m = model_mix(ch, vol, en);
                    ea = (m > 2047) ? 2047 : m; eca = (m > 2047);
                    eb = (m > 511) ? 511 : m;   ecb = (m > 511);
                    exp_stb_at = c + N + 2;
                end else begin
                    next_ovr = 1'b1;
                end
            end
            stb = stb_now;
            step();
            pend_m |= fp;
            exp_busy = (c + 1 >= last_acc + 1) && (c + 1 <= last_acc + N + 1);
            checks++; if (stb_a !== (c + 1 == exp_stb_at)) begin
                failures++; $display("FAIL b2b_stb cyc=%0d got=%b exp=%b", c + 1, stb_a, (c + 1 == exp_stb_at)); end
            checks++; if (ovr_a !== next_ovr) begin
                failures++; $display("FAIL b2b_overrun cyc=%0d got=%b exp=%b", c + 1, ovr_a, next_ovr); end
            checks++; if (busy_a !== exp_busy) begin
                failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c + 1, busy_a, exp_busy); end
            if (c + 1 == exp_stb_at) begin
                checks++; if (sample_a !== 11'(ea) || clip_a !== eca) begin
                    failures++; $display("FAIL b2b_sample_a cyc=%0d got=%0d/%b exp=%0d/%b", c + 1, sample_a, clip_a, ea, eca); end
                checks++; if (sample_b !== 9'(eb) || clip_b !== ecb) begin
                    failures++; $display("FAIL b2b_sample_b cyc=%0d got=%0d/%b exp=%0d/%b", c + 1, sample_b, clip_b, eb, ecb); end
                checks++; if (flags_a !== pend_m) begin
                    failures++; $display("FAIL b2b_flags cyc=%0d got=%b exp=%b", c + 1, flags_a, pend_m); end
                $display("b2b result cyc=%0d sample_a=%0d sample_b=%0d clip_b=%b flags=%b", c + 1, sample_a, sample_b, clip_b, flags_a);
                pend_m = '0;
            end
        end
        stb = 1'b0; fp = '0;
    endtask

    task automatic test_reset_mid_mix;
        int lat; logic [19:0] bt; logic seen_stb;
        ch = {4{9'd300}}; vol = 16'hFFFF; en = 4'b1111; stb = 1'b1;
        seen_stb = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            stb = 1'b0;
            if (stb_a) seen_stb = 1'b1;
            if (k == 4) begin
                checks++; if ({sample_a, stb_a, clip_a, busy_a, ovr_a, flags_a} !== 19'd0) begin
                    failures++; $display("FAIL midreset_outputs got=%h exp=0", {sample_a, stb_a, clip_a, busy_a, ovr_a, flags_a}); end
            end
            rst_n = (k != 3);
        end
        checks++; if (seen_stb !== 1'b0) begin failures++; $display("FAIL midreset_no_stb got=%b exp=0", seen_stb); end
        do_mix({9'd0, 9'd50, 9'd200, 9'd100}, 16'hFFFF, 4'b1111, lat, bt);
        checks++; if (lat !== 6) begin failures++; $display("FAIL midreset_latency got=%0d exp=6", lat); end
        checks++; if (sample_a !== 11'd350) begin failures++; $display("FAIL midreset_sample got=%0d exp=350", sample_a); end
        $display("test_reset_mid_mix lat=%0d sample=%0d", lat, sample_a);
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; ch = '0; vol = '0; en = '0; fp = '0;
        test_reset();
        test_unity();
        test_mute_volume();
        test_saturation();
        test_frame_flags();
        test_overrun();
        test_back_to_back();
        test_reset_mid_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
